// File: rtl/mem_arb_pkg.sv
// Shared types and sizing helpers for the instruction/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, WAIT_IF, WAIT_D} arb_state_t;
  typedef enum logic [1:0] {GNT_NONE, GNT_IF, GNT_D} grant_t;

  localparam int MEM_LAT_DEFAULT = 2;

  // Counter must hold MEM_LAT-1 without wrapping.
  function automatic int cnt_width(input int lat);
    return $clog2(lat + 1);
  endfunction

  localparam int CNT_W_DEFAULT = cnt_width(MEM_LAT_DEFAULT);

endpackage

// File: rtl/mem_port_arbiter_lat_counter.sv
// Access latency down-counter: loads at issue, counts down while busy, flags zero.
module mem_lat_counter
  import mem_arb_pkg::*;
#(
  parameter int W = CNT_W_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between instruction fetch and
// the load/store stage; data has fixed priority, one access in flight at a time.
//
// state   | meaning
// IDLE    | port free; requests sampled here, issue unless halted
// WAIT_IF | fetch access in flight, waiting for the latency to expire
// WAIT_D  | load/store access in flight, waiting for the latency to expire
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            halt,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_ready,
  output logic [XLEN-1:0] if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_ready,
  output logic [XLEN-1:0] d_rdata,
  output logic            mem_en,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            busy
);

  localparam int CNT_W = cnt_width(MEM_LAT);

  arb_state_t state_q, state_d;
  grant_t     grant;
  logic       done_if, done_d;
  logic       cnt_zero;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant   = GNT_NONE;
    done_if = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // Data belongs to an older instruction, so it always wins.
        if (!halt) begin
          if (d_req) begin
            grant   = GNT_D;
            state_d = WAIT_D;
          end else if (if_req) begin
            grant   = GNT_IF;
            state_d = WAIT_IF;
          end
        end
      end
      WAIT_IF: begin
        if (cnt_zero) begin
          done_if = 1'b1;
          state_d = IDLE;
        end
      end
      WAIT_D: begin
        if (cnt_zero) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  mem_lat_counter #(.W(CNT_W)) u_lat_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (grant != GNT_NONE),
    .load_val (CNT_W'(MEM_LAT - 1)),
    .dec      (busy),
    .zero     (cnt_zero)
  );

  // Holding registers keep the memory command stable for the whole access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ready  <= 1'b0;
      if_rdata  <= '0;
      d_ready   <= 1'b0;
      d_rdata   <= '0;
    end else begin
      mem_en   <= (grant != GNT_NONE);
      if_ready <= done_if;
      d_ready  <= done_d;
      if (grant == GNT_D) begin
        mem_addr  <= d_addr;
        mem_we    <= d_we;
        mem_wdata <= d_wdata;
      end else if (grant == GNT_IF) begin
        mem_addr  <= if_addr;
        mem_we    <= 1'b0;
        mem_wdata <= '0;
      end
      if (done_if) begin
        if_rdata <= mem_rdata;
      end
      if (done_d && !mem_we) begin
        d_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic against a
// transaction-timing reference model; two extra instances sweep the latency.
module tb_mem_port_arbiter;

  localparam int LAT = 2;

  logic        clk;
  logic        reset, halt, if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic        if_ready, d_ready, mem_en, mem_we, busy;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

  logic        sw_req;
  logic        s1_if_ready, s1_d_ready, s1_mem_en, s1_mem_we, s1_busy;
  logic [31:0] s1_if_rdata, s1_d_rdata, s1_mem_addr, s1_mem_wdata, s1_mem_rdata;
  logic        s4_if_ready, s4_d_ready, s4_mem_en, s4_mem_we, s4_busy;
  logic [31:0] s4_if_rdata, s4_d_rdata, s4_mem_addr, s4_mem_wdata, s4_mem_rdata;

  int errs = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model: at most one access, described by its issue cycle.
  logic        acc_valid = 1'b0;
  int          acc_t = 0;
  logic        acc_d = 1'b0;
  logic        acc_we = 1'b0;
  logic [31:0] acc_addr = '0, acc_wdata = '0;
  logic [31:0] exp_if_rdata = '0, exp_d_rdata = '0;
  logic        rdy_if_now = 1'b0, rdy_d_now = 1'b0;

  mem_port_arbiter #(.XLEN(32), .MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .halt(halt),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.XLEN(32), .MEM_LAT(1)) dut_l1 (
    .clk(clk), .reset(reset), .halt(1'b0),
    .if_req(sw_req), .if_addr(32'h40), .if_ready(s1_if_ready), .if_rdata(s1_if_rdata),
    .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
    .d_ready(s1_d_ready), .d_rdata(s1_d_rdata),
    .mem_en(s1_mem_en), .mem_we(s1_mem_we), .mem_addr(s1_mem_addr), .mem_wdata(s1_mem_wdata),
    .mem_rdata(s1_mem_rdata), .busy(s1_busy)
  );

  mem_port_arbiter #(.XLEN(32), .MEM_LAT(4)) dut_l4 (
    .clk(clk), .reset(reset), .halt(1'b0),
    .if_req(sw_req), .if_addr(32'h40), .if_ready(s4_if_ready), .if_rdata(s4_if_rdata),
    .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
    .d_ready(s4_d_ready), .d_rdata(s4_d_rdata),
    .mem_en(s4_mem_en), .mem_we(s4_mem_we), .mem_addr(s4_mem_addr), .mem_wdata(s4_mem_wdata),
    .mem_rdata(s4_mem_rdata), .busy(s4_busy)
  );

  assign s1_mem_rdata = s1_mem_addr ^ 32'h5A5A_0000;
  assign s4_mem_rdata = s4_mem_addr ^ 32'h5A5A_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    case (a)
      32'h0000_0004: return 32'h0050_0093;
      32'h0000_0100: return 32'hDEAD_BEEF;
      default:       return {a[15:0] ^ 16'hC3A5, a[15:0] + 16'h1357};
    endcase
  endfunction

  // Memory drives valid data only MEM_LAT-1 cycles after the enable cycle.
  logic [3:0] age = 4'd0;
  always @(posedge clk) begin
    if (mem_en) age <= 4'd1;
    else if (age != 4'd0 && age != 4'd15) age <= age + 4'd1;
  end
  always_comb begin
    mem_rdata = 32'hBADB_AD00;
    if ((mem_en ? 4'd0 : age) == 4'(LAT - 1)) mem_rdata = mem_f(mem_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s cyc=%0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_zero(input string nm, input logic en, we, bz, ir, dr,
                          input logic [31:0] addr, wdata, irdata, drdata);
    chk({nm, "_rst_mem_en"}, 32'(en), 32'd0);
    chk({nm, "_rst_mem_we"}, 32'(we), 32'd0);
    chk({nm, "_rst_busy"}, 32'(bz), 32'd0);
    chk({nm, "_rst_if_ready"}, 32'(ir), 32'd0);
    chk({nm, "_rst_d_ready"}, 32'(dr), 32'd0);
    chk({nm, "_rst_mem_addr"}, addr, 32'd0);
    chk({nm, "_rst_mem_wdata"}, wdata, 32'd0);
    chk({nm, "_rst_if_rdata"}, irdata, 32'd0);
    chk({nm, "_rst_d_rdata"}, drdata, 32'd0);
  endtask

  // Inputs as they stand now are what the DUT samples at the next edge.
  task automatic model_sample();
    if (reset) begin
      acc_valid = 1'b0;
    end else if (!acc_valid && !halt && (d_req || if_req)) begin
      acc_valid = 1'b1;
      acc_t     = cyc + 1;
      acc_d     = d_req;
      acc_addr  = d_req ? d_addr : if_addr;
      acc_we    = d_req && d_we;
      acc_wdata = d_wdata;
    end
  endtask

  task automatic post_check();
    logic en_e, busy_e, rdy_e;
    en_e   = acc_valid && (cyc == acc_t);
    busy_e = acc_valid && (cyc >= acc_t) && (cyc < acc_t + LAT);
    rdy_e  = acc_valid && (cyc == acc_t + LAT);
    rdy_if_now = rdy_e && !acc_d;
    rdy_d_now  = rdy_e && acc_d;
    if (rdy_if_now) exp_if_rdata = mem_f(acc_addr);
    if (rdy_d_now && !acc_we) exp_d_rdata = mem_f(acc_addr);
    chk("mem_en", 32'(mem_en), 32'(en_e));
    chk("busy", 32'(busy), 32'(busy_e));
    chk("if_ready", 32'(if_ready), 32'(rdy_if_now));
    chk("d_ready", 32'(d_ready), 32'(rdy_d_now));
    chk("if_rdata", if_rdata, exp_if_rdata);
    chk("d_rdata", d_rdata, exp_d_rdata);
    if (busy_e) begin
      chk("mem_addr", mem_addr, acc_addr);
      chk("mem_we", 32'(mem_we), 32'(acc_we));
      if (acc_we) chk("mem_wdata", mem_wdata, acc_wdata);
    end
    if (rdy_e) acc_valid = 1'b0;
  endtask

  task automatic tick();
    model_sample();
    @(posedge clk);
    #1;
    cyc++;
    post_check();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (rdy_if_now) if_req = 1'b0;
      if (rdy_d_now) d_req = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    acc_valid    = 1'b0;
    exp_if_rdata = '0;
    exp_d_rdata  = '0;
    chk_zero("main", mem_en, mem_we, busy, if_ready, d_ready, mem_addr, mem_wdata, if_rdata, d_rdata);
    chk_zero("l1", s1_mem_en, s1_mem_we, s1_busy, s1_if_ready, s1_d_ready,
             s1_mem_addr, s1_mem_wdata, s1_if_rdata, s1_d_rdata);
    chk_zero("l4", s4_mem_en, s4_mem_we, s4_busy, s4_if_ready, s4_d_ready,
             s4_mem_addr, s4_mem_wdata, s4_if_rdata, s4_d_rdata);
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Continuous fetch: access k issues at phase k*(L+1) and completes L later.
  task automatic chk_sweep(input string nm, input int l, input int p,
                           input logic en, bz, rdy, we, drdy, input logic [31:0] addr, rdata);
    logic en_e, bz_e, rdy_e;
    en_e  = (p >= 0) && (p % (l + 1) == 0);
    bz_e  = (p >= 0) && (p % (l + 1) < l);
    rdy_e = (p >= 0) && (p % (l + 1) == l);
    chk({nm, "_mem_en"}, 32'(en), 32'(en_e));
    chk({nm, "_busy"}, 32'(bz), 32'(bz_e));
    chk({nm, "_if_ready"}, 32'(rdy), 32'(rdy_e));
    chk({nm, "_mem_we"}, 32'(we), 32'd0);
    chk({nm, "_d_ready"}, 32'(drdy), 32'd0);
    if (bz_e) chk({nm, "_mem_addr"}, addr, 32'h40);
    if (rdy_e) chk({nm, "_if_rdata"}, rdata, 32'h5A5A_0040);
  endtask

  initial begin
    int c0;
    reset = 1'b0; halt = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; sw_req = 1'b0;
    #1;
    do_reset();

    // Single fetch.
    if_req = 1'b1; if_addr = 32'h4;
    run(4);
    chk("fetch_insn", if_rdata, 32'h0050_0093);

    // Simultaneous requests: data first, fetch right after.
    if_req = 1'b1; if_addr = 32'h8;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    run(7);
    chk("load_data", d_rdata, 32'hDEAD_BEEF);
    chk("fetch_after_load", if_rdata, mem_f(32'h8));

    // Store leaves d_rdata alone.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h1234_5678;
    run(4);
    d_we = 1'b0;
    chk("store_keeps_rdata", d_rdata, 32'hDEAD_BEEF);

    // Halt blocks issue from IDLE.
    halt = 1'b1; if_req = 1'b1; if_addr = 32'hC;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("halt_no_en", 32'(mem_en), 32'd0);
    end
    halt = 1'b0;
    run(4);

    // Reset during WAIT_D abandons the access; a fresh one then completes.
    d_req = 1'b1; d_addr = 32'h100;
    tick();
    tick();
    do_reset();
    run(5);
    chk("load_after_reset", d_rdata, 32'hDEAD_BEEF);

    // Random traffic with random halt and mid-access request drops.
    if_req = 1'b0; d_req = 1'b0; halt = 1'b0;
    for (int i = 0; i < 400; i++) begin
      halt = ($urandom_range(0, 5) == 0);
      if (acc_valid && !acc_d) begin
        if ($urandom_range(0, 7) == 0) if_req = 1'b0;
      end else if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req  = 1'b1;
        if_addr = 32'($urandom_range(0, 255)) << 2;
      end
      if (acc_valid && acc_d) begin
        if ($urandom_range(0, 7) == 0) d_req = 1'b0;
      end else if (!d_req && $urandom_range(0, 3) == 0) begin
        d_req   = 1'b1;
        d_we    = $urandom_range(0, 1) == 1;
        d_addr  = 32'($urandom_range(0, 255)) << 2;
        d_wdata = $urandom;
      end
      tick();
      if (rdy_if_now) if_req = 1'b0;
      if (rdy_d_now) d_req = 1'b0;
    end

    // Latency sweep on the MEM_LAT=1 and MEM_LAT=4 instances.
    if_req = 1'b0; d_req = 1'b0; halt = 1'b0;
    run(6);
    sw_req = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 30; i++) begin
      tick();
      chk_sweep("l1", 1, cyc - (c0 + 1), s1_mem_en, s1_busy, s1_if_ready, s1_mem_we,
                s1_d_ready, s1_mem_addr, s1_if_rdata);
      chk_sweep("l4", 4, cyc - (c0 + 1), s4_mem_en, s4_busy, s4_if_ready, s4_mem_we,
                s4_d_ready, s4_mem_addr, s4_if_rdata);
    end
    sw_req = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer that shares one single-port, fixed-latency memory between the instruction-fetch stage and the load/store (MEM) stage of the RISC-V core. It grants one requester at a time and holds the memory port until that access completes. It returns read data and a one-cycle ready pulse to the winner, and blocks new grants while the core is halted. It sits between the pipeline stages and the unified memory model, replacing separate instruction and data memories.

## Interface
- XLEN, 32, address/data width
- MEM_LAT, 2, memory cycles from the enable cycle to valid rdata (≥1)
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-high
- halt  in  1  core halt; no new grant while high
- if_req  in  1  fetch request, held until if_ready
- if_addr  in  XLEN  fetch address
- if_ready  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  XLEN  fetched instruction
- d_req  in  1  data request (from MemRead|MemWrite), held until d_ready
- d_we  in  1  1 = store
- d_addr  in  XLEN  data address
- d_wdata  in  XLEN  store data
- d_ready  out  1  one-cycle pulse: access done; d_rdata valid for loads
- d_rdata  out  XLEN  load data
- mem_en, mem_we  out  1 each  memory strobe (one cycle per access) and write enable
- mem_addr, mem_wdata  out  XLEN  memory address and write data
- mem_rdata  in  XLEN  memory read data
- busy  out  1  access in flight

## Operation
- FSM states: IDLE, WAIT_IF, WAIT_D.
- IDLE with halt=0:
  - d_req=1 → issue data access, go to WAIT_D.
  - else if_req=1 → issue fetch (mem_we=0), go to WAIT_IF.
  - else stay in IDLE.
- Fixed priority: data beats fetch. A pending load/store belongs to an older instruction; fetch starvation is acceptable because the pipeline stalls on data anyway.
- Issue: assert mem_en for exactly one cycle. mem_addr, mem_we and mem_wdata come from the winner and are latched into holding registers. They stay stable on the mem_* outputs until the access completes.
- WAIT_*: the latency counter loads MEM_LAT-1 at issue and decrements each cycle.
  - At 0, capture mem_rdata into the winner's rdata register and pulse its ready for one cycle, then return to IDLE.
  - Stores complete on the same schedule; d_rdata is unchanged on a store.
- rdata registers hold their value until the next completion for that requester.
- halt=1 blocks issue from IDLE only; an in-flight access always completes. Deasserting halt allows issue on that same cycle.
- If a requester drops its req mid-access, the access still completes and ready still pulses.
- busy = (state != IDLE).
- Reset (at any time, including mid-access): state IDLE, counter 0, all outputs 0, rdata registers 0. The in-flight access is abandoned.

## Timing
- Issue cycle T (mem_en=1) → ready pulse at T+MEM_LAT. The pulse is registered, so no combinational path from req to ready.
- Next issue no earlier than T+MEM_LAT+1 (IDLE lasts one cycle). Back-to-back throughput is one access per MEM_LAT+1 cycles.
- mem_en is registered, so issue happens on the cycle after the req is sampled high in IDLE.
- Requests arriving during WAIT_* are evaluated on the IDLE cycle that follows.
- When both requests are pending, data is served first; fetch issues on the IDLE cycle after d_ready.

## Structure
- Package mem_arb_pkg:
  - arb_state_t enum {IDLE, WAIT_IF, WAIT_D}.
  - grant_t enum {GNT_NONE, GNT_IF, GNT_D}.
  - Localparam for the counter width, $clog2(MEM_LAT+1).
- One natural sub-module: mem_lat_counter (load, decrement, zero flag).

## Test plan
- Reset, then if_req, if_addr=0x00000004, memory returns 0x00500093 (MEM_LAT=2) → one mem_en pulse at T; if_ready high exactly at T+2 with if_rdata=0x00500093.
- d_req and if_req rise together; load from 0x100 returns 0xDEADBEEF → data issues first and d_ready pulses with d_rdata=0xDEADBEEF; fetch mem_en follows on the next IDLE cycle.
- Store d_we=1, d_addr=0x20, d_wdata=0x12345678 → mem_we=1 with the latched address and data; d_ready pulses at T+2; d_rdata unchanged.
- halt=1 with if_req high for 10 cycles → no mem_en and busy=0; release halt → issue on that cycle.
- Assert reset during WAIT_D → all outputs 0 immediately; no ready pulse; fresh access completes normally after reset.
- Sweep MEM_LAT=1 and MEM_LAT=4 with continuous if_req → ready spacing of 2 and 5 cycles respectively.
